// File: rtl/lgn_pixel_packer.sv
// lgn_pixel_packer: binarizes a grayscale pixel stream and packs 8 pixels
// per byte into the logic-gate-network classifier's input shift register.
module lgn_pixel_packer #(
  parameter int PIXELS        = 784,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  input  logic       pix_sof,
  output logic       pix_ready,
  input  logic [7:0] threshold,
  output logic [7:0] out_byte,
  output logic       write_enable,
  output logic       busy,
  output logic       frame_done,
  output logic       sof_error
);

  localparam int CW = $clog2(PIXELS);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST  = CW'(PIXELS - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    SETTLE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [SW-1:0] scnt, scnt_d;
  logic [7:0]    pack, pack_d;
  logic [7:0]    thr_q, thr_d;
  logic [7:0]    byte_d;
  logic          we_d, done_d, err_d;

  logic          acc, sof_acc, bin;
  logic [7:0]    thr_use, shifted;

  assign pix_ready = (state != SETTLE);
  assign busy      = (state != IDLE);
  assign acc       = pix_valid & pix_ready;
  assign sof_acc   = acc & pix_sof;
  // An SOF pixel is binarized against the threshold being latched with it
  assign thr_use   = sof_acc ? threshold : thr_q;
  assign bin       = (pix_data >= thr_use);
  assign shifted   = {pack[6:0], bin};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    scnt_d  = scnt;
    pack_d  = pack;
    thr_d   = thr_q;
    byte_d  = out_byte;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sof_acc) begin
          state_d = PACK;
          thr_d   = threshold;
          pack_d  = {7'b0, bin};
          cnt_d   = CW'(1);
        end
      end
      PACK: begin
        if (sof_acc) begin
          err_d  = 1'b1;
          thr_d  = threshold;
          pack_d = {7'b0, bin};
          cnt_d  = CW'(1);
        end else if (acc) begin
          pack_d = shifted;
          cnt_d  = cnt + CW'(1);
          if (cnt[2:0] == 3'd7) begin
            we_d   = 1'b1;
            byte_d = shifted;
          end
          if (cnt == LAST) begin
            state_d = SETTLE;
            cnt_d   = '0;
            scnt_d  = '0;
          end
        end
      end
      SETTLE: begin
        scnt_d = scnt + SW'(1);
        if (scnt == SLAST) begin
          state_d = IDLE;
          scnt_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      scnt         <= '0;
      pack         <= '0;
      thr_q        <= '0;
      out_byte     <= '0;
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      sof_error    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      scnt         <= scnt_d;
      pack         <= pack_d;
      thr_q        <= thr_d;
      out_byte     <= byte_d;
      write_enable <= we_d;
      frame_done   <= done_d;
      sof_error    <= err_d;
    end
  end

endmodule

// File: tb/tb_lgn_pixel_packer.sv
// tb_lgn_pixel_packer: random-gap stimulus against a frame-level model
// (bit queue per frame, settle countdown) plus literal frame checks.
module tb_lgn_pixel_packer;

  localparam int PIX = 784;
  localparam int SET = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] threshold = '0;
  logic       pix_ready;
  logic [7:0] out_byte;
  logic       write_enable;
  logic       busy;
  logic       frame_done;
  logic       sof_error;

  lgn_pixel_packer #(
    .PIXELS       (PIX),
    .SETTLE_CYCLES(SET)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .threshold   (threshold),
    .out_byte    (out_byte),
    .write_enable(write_enable),
    .busy        (busy),
    .frame_done  (frame_done),
    .sof_error   (sof_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         bits[$];
  int         m_thr = 0;
  bit         in_frame = 0;
  int         settle_left = 0;
  bit         e_we = 0, e_done = 0, e_err = 0;
  logic [7:0] e_byte = '0;
  int         ecount = 0;
  int         last_edge = 0;
  int         nb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits.delete();
      m_thr       = 0;
      in_frame    = 0;
      settle_left = 0;
      e_we        = 0;
      e_done      = 0;
      e_err       = 0;
    end else begin
      ecount++;
      e_we   = 0;
      e_done = 0;
      e_err  = 0;
      if (settle_left > 0) begin
        settle_left--;
        if (settle_left == 0) e_done = 1;
      end else if (pix_valid) begin
        if (pix_sof) begin
          e_err    = in_frame;
          in_frame = 1;
          m_thr    = int'(threshold);
          bits.delete();
        end
        if (in_frame) begin
          bits.push_back(int'(pix_data) >= m_thr);
          nb = bits.size();
          if (nb % 8 == 0) begin
            e_we   = 1;
            e_byte = '0;
            for (int j = 0; j < 8; j++)
              e_byte = 8'((int'(e_byte) * 2) + int'(bits[nb - 8 + j]));
          end
          if (nb == PIX) begin
            in_frame    = 0;
            settle_left = SET;
            last_edge   = ecount;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pix_ready", pix_ready, settle_left == 0);
      chk("write_enable", write_enable, e_we);
      if (e_we) chk("out_byte", out_byte, e_byte);
      chk("busy", busy, in_frame || settle_left > 0);
      chk("frame_done", frame_done, e_done);
      chk("sof_error", sof_error, e_err);
    end
  end

  // ---------------- DUT activity log ----------------
  logic [7:0] wq[$];
  int dcnt = 0, ecnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (write_enable) wq.push_back(out_byte);
      if (frame_done) begin
        dcnt++;
        done_cyc = ecount + 1;
      end
      if (sof_error) ecnt++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] pixel(input int kind, input int i);
    case (kind)
      0: return 8'hFF;
      1: return (i % 2) ? 8'd10 : 8'd200;
      2: return (i % 2) ? 8'd10 : 8'd100;
      3: return 8'h40;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic px(input logic [7:0] d, input logic sof,
                    input logic [7:0] th, input int gap);
    bit got;
    bit rdy;
    int budget;
    got = 0;
    budget = 0;
    while (!got) begin
      @(negedge clk);
      pix_data  = d;
      pix_sof   = sof;
      threshold = th;
      pix_valid = ($urandom_range(99) >= gap);
      rdy = pix_ready;
      @(posedge clk);
      if (pix_valid && rdy) got = 1;
      budget++;
      if (!got && budget > 300) begin
        chk("accept_timeout", 0, 1);
        got = 1;
      end
    end
  endtask

  task automatic frame(input int kind, input int n, input int gap,
                       input logic [7:0] t0, input logic [7:0] t1,
                       input int tsw);
    for (int i = 0; i < n; i++)
      px(pixel(kind, i), i == 0, (i < tsw) ? t0 : t1, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  task automatic chk_bytes(input string nm, input int n,
                           input logic [7:0] v);
    chk({nm, "_count"}, wq.size(), n);
    foreach (wq[k]) chk(nm, wq[k], v);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int d0, e0;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", pix_ready, 1);
    chk("rst_we", write_enable, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", sof_error, 0);
    rst_n = 1'b1;
    idle(2);

    wq.delete();
    frame(0, PIX, 0, 8'h80, 8'h80, PIX);
    idle(5);
    chk_bytes("ff_frame", 98, 8'hFF);
    chk("done_latency", done_cyc - last_edge, 3);
    chk("busy_after", busy, 0);
    chk("done_count", dcnt, 1);

    wq.delete();
    frame(1, PIX, 0, 8'd100, 8'd100, PIX);
    idle(4);
    chk_bytes("alt_frame", 98, 8'hAA);

    wq.delete();
    frame(2, PIX, 0, 8'd100, 8'd100, PIX);
    idle(4);
    chk_bytes("eq_frame", 98, 8'hAA);

    wq.delete();
    px(8'h55, 1'b0, 8'h00, 0);
    idle(3);
    chk("discard_nowrite", wq.size(), 0);
    chk("discard_busy", busy, 0);
    frame(1, PIX, 50, 8'd100, 8'd100, PIX);
    idle(4);
    chk_bytes("gap_frame", 98, 8'hAA);

    wq.delete();
    e0 = ecnt;
    frame(1, 300, 0, 8'd100, 8'd100, PIX);
    chk("pre_restart_writes", wq.size(), 37);
    frame(1, PIX, 0, 8'd100, 8'd100, PIX);
    idle(4);
    chk("restart_writes", wq.size(), 135);
    chk("sof_err_count", ecnt - e0, 1);

    wq.delete();
    frame(3, PIX, 0, 8'h80, 8'h10, 400);
    idle(4);
    chk_bytes("thr_mid_frame", 98, 8'h00);
    wq.delete();
    frame(3, PIX, 0, 8'h10, 8'h10, PIX);
    idle(4);
    chk_bytes("thr_next_frame", 98, 8'hFF);

    frame(0, 400, 0, 8'h80, 8'h80, PIX);
    #3;
    chk("busy_before_rst", busy, 1);
    d0 = dcnt;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", pix_ready, 1);
    chk("arst_we", write_enable, 0);
    chk("arst_byte", out_byte, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_err", sof_error, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk("no_done_after_rst", dcnt, d0);
    wq.delete();
    frame(4, PIX, 30, 8'($urandom), 8'($urandom), PIX);
    idle(4);
    chk("post_rst_writes", wq.size(), 98);
    chk("post_rst_done", dcnt, d0 + 1);

    wq.delete();
    frame(4, PIX, 20, 8'($urandom), 8'($urandom), 500);
    frame(4, PIX, 0, 8'($urandom), 8'($urandom), PIX);
    idle(5);
    chk("b2b_writes", wq.size(), 196);
    chk("b2b_done", dcnt, d0 + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
